// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control-bit positions and NOP encoding for the ID/EX, EX/MEM and MEM/WB stage registers
package pipe_pkg;
  localparam int ID_EX_CTRL_W = 9;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int MEM_WB_CTRL_W = 2;
  localparam int ID_EX_DATA_W = 32 * 4 + 5 + 5;
  localparam int EX_MEM_DATA_W = 32 * 3 + 1 + 5;
  localparam int MEM_WB_DATA_W = 32 * 2 + 5;
  localparam int C_REG_DST = 8;
  localparam int C_REG_WRITE = 7;
  localparam int C_BRANCH = 6;
  localparam int C_MEM_READ = 5;
  localparam int C_MEM_WRITE = 4;
  localparam int C_ALU_SRC = 3;
  localparam int C_MEM_TO_REG = 2;
  localparam int C_ALU_OP_LO = 0;
  localparam logic [ID_EX_CTRL_W-1:0] CTRL_NOP_ENC = '0;
  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } id_ex_ctrl_t;
  typedef struct packed {
    logic reg_write;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_mem_ctrl_t;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;
  function automatic ex_mem_ctrl_t ex_mem_ctrl(id_ex_ctrl_t c);
    return '{c.reg_write, c.branch, c.mem_read, c.mem_write, c.mem_to_reg};
  endfunction
  function automatic mem_wb_ctrl_t mem_wb_ctrl(ex_mem_ctrl_t c);
    return '{c.reg_write, c.mem_to_reg};
  endfunction
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid+ctrl+data holding register with load and clear (clear wins)
module pipe_skid_slot #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 138
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  always_comb begin
    valid_d = clear ? 1'b0 : load ? 1'b1 : valid_q;
    ctrl_d = (load && !clear) ? in_ctrl : ctrl_q;
    data_d = (load && !clear) ? in_data : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end
  assign valid = valid_q;
  assign ctrl = ctrl_q;
  assign data = data_q;
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline stage register with flush and bubble insertion; PIPE_STAGE_SKID_EN adds a skid slot and a registered in_ready
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              xfer_in, main_take, main_load;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  assign xfer_in = in_valid & in_ready;
  assign main_take = !main_valid_q | out_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic in_ready_q, in_ready_d, skid_load, skid_clear;
  always_comb begin
    skid_load = !flush & xfer_in & !main_take;
    skid_clear = flush | (main_take & skid_valid);
    in_ready_d = !(skid_load | (skid_valid & !skid_clear));
  end
  pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_q <= 1'b1;
    else in_ready_q <= in_ready_d;
  end
  assign in_ready = in_ready_q;
`else
  assign skid_valid = 1'b0;
  assign skid_ctrl = '0;
  assign skid_data = '0;
  assign in_ready = main_take;
`endif
  // a held skid entry is older than the input, so it refills the main register first
  always_comb begin
    main_load = !flush & main_take & (skid_valid | xfer_in);
    main_valid_d = flush ? 1'b0 : main_take ? main_load : 1'b1;
    main_ctrl_d = main_load ? (skid_valid ? skid_ctrl : in_ctrl) : main_ctrl_q;
    main_data_d = main_load ? (skid_valid ? skid_data : in_data) : main_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q <= CTRL_NOP;
      main_data_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end
  assign out_valid = main_valid_q;
  assign out_ctrl = main_valid_q ? main_ctrl_q : CTRL_NOP;
  assign out_data = main_data_q;
  assign occ = {1'b0, main_valid_q} + {1'b0, skid_valid};
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: table vectors, corner sequences and a FIFO-queue reference model for pipe_stage
module tb_pipe_stage;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [8:0]   in_ctrl = '0;
  logic [137:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [8:0]   out_ctrl;
  logic [137:0] out_data;
  logic [1:0]   occ;
  int n_chk = 0;
  int n_fail = 0;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [8:0]   c;
    logic [137:0] d;
  } ent_t;
  ent_t         q[$];
  logic [137:0] hold_d = '0;
  function automatic bit m_ready(bit ordy);
    if (CAP == 2) return q.size() < 2;
    return q.size() == 0 || ordy;
  endfunction
  task automatic model_edge(bit iv, bit ordy, bit fl, logic [8:0] c, logic [137:0] d);
    bit rdy;
    rdy = m_ready(ordy);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && rdy) q.push_back('{c, d});
    end
    if (q.size() > 0) hold_d = q[0].d;
  endtask
  task automatic model_reset();
    q.delete();
    hold_d = '0;
  endtask
  task automatic chk(string n, logic [137:0] got, logic [137:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic chk_out(string n, bit ev, logic [8:0] ec, logic [137:0] ed, logic [1:0] eo);
    chk({n, ".out_valid"}, 138'(out_valid), 138'(ev));
    chk({n, ".out_ctrl"}, 138'(out_ctrl), 138'(ec));
    chk({n, ".out_data"}, out_data, ed);
    chk({n, ".occ"}, 138'(occ), 138'(eo));
  endtask
  task automatic chk_model(string n);
    chk_out(n, q.size() > 0, q.size() > 0 ? q[0].c : 9'h0, q.size() > 0 ? q[0].d : hold_d, 2'(q.size()));
  endtask
  task automatic step(bit iv, bit ordy, bit fl, logic [8:0] c, logic [137:0] d);
    in_valid = iv;
    out_ready = ordy;
    flush = fl;
    in_ctrl = c;
    in_data = d;
    #1;
    chk("in_ready", 138'(in_ready), 138'(m_ready(ordy)));
    @(posedge clk);
    model_edge(iv, ordy, fl, c, d);
    #1;
  endtask
  task automatic do_reset();
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  typedef struct {
    bit           iv, ordy;
    logic [8:0]   c;
    logic [137:0] d;
    bit           ev;
    logic [8:0]   ec;
    logic [137:0] ed;
    logic [1:0]   eo;
  } vec_t;
  function automatic vec_t mkv(bit iv, bit ordy, int c, int d, bit ev, int ec, int ed, int eo);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.c = 9'(c); v.d = 138'(d);
    v.ev = ev; v.ec = 9'(ec); v.ed = 138'(ed); v.eo = 2'(eo);
    return v;
  endfunction
  vec_t tbl[12];
  logic [137:0] va, vb, vc;
  logic [159:0] w;
  initial begin
    va = 138'h2AAAA_0000_1111_2222_3333_4444_5555_6666;
    vb = 138'h15555_7777_8888_9999_AAAA_BBBB_CCCC_DDDD;
    vc = 138'h3FFFF_0123_4567_89AB_CDEF_0123_4567_89AB;
    for (int k = 1; k <= 8; k++) tbl[k-1] = mkv(1, 1, k, k, 1, k, k, 1);
    tbl[8] = mkv(0, 1, 0, 0, 0, 0, 8, 0);
    tbl[9] = mkv(1, 1, 9, 9, 1, 9, 9, 1);
    tbl[10] = mkv(1, 1, 10, 10, 1, 10, 10, 1);
    tbl[11] = mkv(0, 0, 0, 0, 1, 10, 10, 1);
    rst = 1;
    in_valid = 1;
    in_ctrl = 9'h1FF;
    in_data = va;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    chk_out("reset", 0, 9'h0, '0, 0);
    chk("reset.in_ready", 138'(in_ready), 138'(1));
    step(1, 1, 0, 9'h1FF, va);
    chk_out("first_edge", 1, 9'h1FF, va, 1);
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].ordy, 0, tbl[i].c, tbl[i].d);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].ed, tbl[i].eo);
    end
    step(0, 1, 0, 0, '0);
    chk_out("drain", 0, 9'h0, 138'(10), 0);
`ifdef PIPE_STAGE_SKID_EN
    step(1, 0, 0, 9'h0A1, va);
    chk_out("stall_a", 1, 9'h0A1, va, 1);
    chk("stall_a.in_ready", 138'(in_ready), 138'(1));
    step(1, 0, 0, 9'h0B2, vb);
    chk_out("stall_b", 1, 9'h0A1, va, 2);
    chk("stall_b.in_ready", 138'(in_ready), 138'(0));
    step(0, 1, 0, 0, '0);
    chk_out("release_b", 1, 9'h0B2, vb, 1);
    step(0, 1, 0, 0, '0);
    chk_out("release_empty", 0, 9'h0, vb, 0);
    step(1, 0, 0, 9'h0A1, va);
    step(1, 0, 0, 9'h0B2, vb);
    chk_out("pre_flush", 1, 9'h0A1, va, 2);
    step(1, 0, 1, 9'h0C3, vc);
    chk_out("flush", 0, 9'h0, va, 0);
    step(0, 1, 0, 0, '0);
    chk_out("flush_drop", 0, 9'h0, va, 0);
    step(1, 0, 0, 9'h0A1, va);
    step(1, 0, 0, 9'h0B2, vb);
    chk_out("pre_arst", 1, 9'h0A1, va, 2);
`else
    step(1, 0, 0, 9'h0A1, va);
    chk_out("stall_a", 1, 9'h0A1, va, 1);
    step(1, 0, 0, 9'h0B2, vb);
    chk_out("stall_b_refused", 1, 9'h0A1, va, 1);
    step(0, 1, 0, 0, '0);
    chk_out("release_empty", 0, 9'h0, va, 0);
    step(1, 0, 0, 9'h0B2, vb);
    chk_out("pre_flush", 1, 9'h0B2, vb, 1);
    step(1, 0, 1, 9'h0C3, vc);
    chk_out("flush", 0, 9'h0, vb, 0);
    step(0, 1, 0, 0, '0);
    chk_out("flush_drop", 0, 9'h0, vb, 0);
    step(1, 0, 0, 9'h0A1, va);
    chk_out("pre_arst", 1, 9'h0A1, va, 1);
`endif
    in_valid = 0;
    #3;
    rst = 1;
    #1;
    chk_out("async_rst", 0, 9'h0, '0, 0);
    chk("async_rst.in_ready", 138'(in_ready), 138'(1));
    model_reset();
    #1;
    rst = 0;
    for (int i = 0; i < 400; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           9'($urandom), w[137:0]);
      chk_model($sformatf("rnd%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised, flow-controlled pipeline stage register that replaces the fixed-field stage latches between ID/EX, EX/MEM and MEM/WB. It carries a control field and a data payload from one stage to the next with a valid/ready handshake, stall back-pressure, synchronous flush, and bubble insertion. An optional skid slot registers the ready path.

## Interface
Parameters:
- CTRL_W, 9: width of the control field (RegDst, RegWrite, Branch, MemRead, MemWrite, ALUSrc, MemtoReg, ALUOp packed).
- DATA_W, 138: width of the payload (pc_plus_4, rdata1, rdata2, const_or_addr, rt, rd packed).
- CTRL_NOP, 0: control value presented whenever the stage holds no valid entry.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  control field; equals CTRL_NOP when out_valid=0.
- out_data  out  DATA_W  payload; holds last value when out_valid=0.
- occ  out  2  entries held (0..2).

## Operation
- Transfer in: in_valid & in_ready at a clk edge. Transfer out: out_valid & out_ready at a clk edge.
- The main register drives the outputs. On a transfer out, the main register loads the skid entry if one is held, else loads the input transfer, else becomes empty.
- If the main register is full, no transfer out occurs, and a transfer in occurs, the input goes to the skid slot. This applies only with SKID_EN.
- Bubble: an empty main register forces out_ctrl=CTRL_NOP. Downstream never sees stale RegWrite or MemWrite.
- Flush has priority over everything. At the edge it clears both valid bits and drops any input transfer in the same cycle. out_ctrl becomes CTRL_NOP, and out_data is unchanged.
- Stall: with out_ready=0, the outputs hold bit-exact. No entry is lost or duplicated.
- occ = main valid + skid valid. It is updated at the same edge as the valid bits.

## Timing
- Latency: 1 cycle from transfer in to out_valid, when the stage is empty.
- Throughput: 1 transfer per cycle with out_ready held at 1.
- Reset values: out_valid=0, out_ctrl=CTRL_NOP, out_data=0, occ=0, in_ready=1, skid empty.
- Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- Simultaneous transfer in and out with the skid empty: the main register loads the input and out_valid stays 1.
- Simultaneous transfer in and out with the skid full cannot occur, because in_ready=0 in that case.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - 2-entry operation.
  - in_ready is a flop, equal to !skid_valid, with no combinational path from out_ready.
  - occ ranges 0..2.
- PIPE_STAGE_SKID_EN undefined:
  - No skid slot.
  - in_ready = !out_valid | out_ready, which is combinational.
  - occ ranges 0..1, with bit 1 tied to 0.
  - Behaviour otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - the control-field width constants and bit positions for the ID/EX, EX/MEM and MEM/WB control groups;
  - the CTRL_NOP encoding;
  - the packed payload widths per stage boundary.
- One sub-module, pipe_skid_slot: a single valid+ctrl+data holding register with load/clear. It is instantiated only under PIPE_STAGE_SKID_EN.

## Test plan
- Reset with in_valid=1, in_ctrl=9'h1FF, then release reset -> out_valid=0, out_ctrl=0, occ=0, in_ready=1. First edge: out_valid=1, out_ctrl=9'h1FF.
- Stream data 1..8 with out_ready=1 for 8 cycles -> out_data=1..8 on consecutive cycles, 1-cycle latency, occ=1 throughout.
- Hold out_ready=0 while sending A then B (SKID_EN) -> out_data stays A, occ=2, in_ready=0. Raise out_ready -> A, then B on the next cycle, with no loss.
- Assert flush with occ=2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_NOP, occ=0, and the input is dropped.
- Drop in_valid for one cycle mid-stream -> one bubble cycle with out_ctrl=CTRL_NOP and out_data held.
- Assert rst asynchronously between edges with occ=2 -> out_valid and occ go to 0 before the next edge.
